// File: rtl/perf_run_controller.sv
// perf_run_controller: run-control and performance-statistics sequencer.
// Counts cycles, retired instructions and stalls during a measured run.
// After halt it drains a few cycles, then runs a restoring divider to form IPC.
// The frozen snapshot is offered through a valid/ready report handshake.
module perf_run_controller #(
    parameter int CNT_W        = 32,
    parameter int FRAC_W       = 8,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt,
    input  logic              instr_retire,
    input  logic              stall,
    input  logic              clear,
    input  logic              report_ready,
    output logic              running,
    output logic              busy,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instr_count,
    output logic [CNT_W-1:0]  stall_count,
    output logic [FRAC_W+7:0] ipc_q,
    output logic              overflow,
    output logic              report_valid
);
    localparam int Q_W     = CNT_W + FRAC_W;
    localparam int IPC_W   = FRAC_W + 8;
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 2);
    localparam int DIV_CW  = $clog2(Q_W + 2);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [Q_W-1:0]   IPC_MAX_Q = Q_W'({IPC_W{1'b1}});

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_DIVIDE = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    state_t state_r, next_state_s;

    logic [CNT_W-1:0]   cycle_count_r, instr_count_r, stall_count_r;
    logic               overflow_r, running_r, busy_r, report_valid_r;
    logic [IPC_W-1:0]   ipc_r;
    logic [DRAIN_W-1:0] drain_cnt_r;
    logic [DIV_CW-1:0]  div_cnt_r;
    logic [Q_W-1:0]     dvd_r, quot_r, q_next_s;
    logic [CNT_W:0]     rem_r, rem_shift_s, rem_next_s, divisor_s;
    logic               sub_ok_s, zero_req_s, count_en_s, div_done_s;
    logic [IPC_W-1:0]   ipc_result_s;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value, input logic inc);
        logic [CNT_W-1:0] result;
        if (inc && (value != CNT_MAX)) begin
            result = value + CNT_W'(1);
        end else begin
            result = value;
        end
        return result;
    endfunction

    // True when an increment is attempted on a counter already at its ceiling.
    function automatic logic sat_hit(input logic [CNT_W-1:0] value, input logic inc);
        return inc && (value == CNT_MAX);
    endfunction

    // Next-state and control decode for the run sequencer.
    always_comb begin
        next_state_s = state_r;
        zero_req_s   = 1'b0;
        count_en_s   = 1'b0;
        div_done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    zero_req_s   = 1'b1;
                    next_state_s = ST_RUN;
                end else if (clear) begin
                    zero_req_s   = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                count_en_s = 1'b1;
                if (halt) begin
                    next_state_s = (DRAIN_CYCLES > 0) ? ST_DRAIN : ST_DIVIDE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                count_en_s = 1'b1;
                if (drain_cnt_r <= DRAIN_W'(1)) begin
                    next_state_s = ST_DIVIDE;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_DIVIDE: begin
                if (div_cnt_r == DIV_CW'(Q_W)) begin
                    div_done_s   = 1'b1;
                    next_state_s = ST_REPORT;
                end else begin
                    next_state_s = ST_DIVIDE;
                end
            end
            ST_REPORT: begin
                if (report_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_REPORT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // One restoring-division step plus final saturation of the quotient.
    always_comb begin
        rem_shift_s = (rem_r << 1) | {{CNT_W{1'b0}}, dvd_r[Q_W-1]};
        divisor_s   = {1'b0, cycle_count_r};
        sub_ok_s    = (rem_shift_s >= divisor_s);
        if (sub_ok_s) begin
            rem_next_s = rem_shift_s - divisor_s;
        end else begin
            rem_next_s = rem_shift_s;
        end
        q_next_s = (quot_r << 1) | {{(Q_W-1){1'b0}}, sub_ok_s};
        if (cycle_count_r == {CNT_W{1'b0}}) begin
            ipc_result_s = {IPC_W{1'b0}};
        end else if (q_next_s > IPC_MAX_Q) begin
            ipc_result_s = {IPC_W{1'b1}};
        end else begin
            ipc_result_s = q_next_s[IPC_W-1:0];
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Saturating statistics counters and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n || zero_req_s) begin
            cycle_count_r <= {CNT_W{1'b0}};
            instr_count_r <= {CNT_W{1'b0}};
            stall_count_r <= {CNT_W{1'b0}};
            overflow_r    <= 1'b0;
        end else if (count_en_s) begin
            cycle_count_r <= sat_inc(cycle_count_r, 1'b1);
            instr_count_r <= sat_inc(instr_count_r, instr_retire);
            stall_count_r <= sat_inc(stall_count_r, stall);
            overflow_r    <= overflow_r | sat_hit(cycle_count_r, 1'b1)
                           | sat_hit(instr_count_r, instr_retire)
                           | sat_hit(stall_count_r, stall);
        end else begin
            cycle_count_r <= cycle_count_r;
            instr_count_r <= instr_count_r;
            stall_count_r <= stall_count_r;
            overflow_r    <= overflow_r;
        end
    end

    // Drain down-counter, armed every RUN cycle so it is ready when halt arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drain_cnt_r <= {DRAIN_W{1'b0}};
        end else if (state_r == ST_RUN) begin
            drain_cnt_r <= DRAIN_W'(DRAIN_CYCLES);
        end else if (state_r == ST_DRAIN) begin
            drain_cnt_r <= drain_cnt_r - DRAIN_W'(1);
        end else begin
            drain_cnt_r <= drain_cnt_r;
        end
    end

    // Divider: first DIVIDE cycle loads operands, then one quotient bit per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvd_r     <= {Q_W{1'b0}};
            rem_r     <= {(CNT_W+1){1'b0}};
            quot_r    <= {Q_W{1'b0}};
            div_cnt_r <= {DIV_CW{1'b0}};
            ipc_r     <= {IPC_W{1'b0}};
        end else if (zero_req_s) begin
            div_cnt_r <= {DIV_CW{1'b0}};
            ipc_r     <= {IPC_W{1'b0}};
        end else if (state_r == ST_DIVIDE) begin
            if (div_cnt_r == {DIV_CW{1'b0}}) begin
                dvd_r  <= {instr_count_r, {FRAC_W{1'b0}}};
                rem_r  <= {(CNT_W+1){1'b0}};
                quot_r <= {Q_W{1'b0}};
            end else begin
                dvd_r  <= dvd_r << 1;
                rem_r  <= rem_next_s;
                quot_r <= q_next_s;
            end
            div_cnt_r <= div_cnt_r + DIV_CW'(1);
            if (div_done_s) begin
                ipc_r <= ipc_result_s;
            end else begin
                ipc_r <= ipc_r;
            end
        end else begin
            div_cnt_r <= {DIV_CW{1'b0}};
        end
    end

    // Registered status flags derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running_r      <= 1'b0;
            busy_r         <= 1'b0;
            report_valid_r <= 1'b0;
        end else begin
            running_r      <= (next_state_s == ST_RUN) || (next_state_s == ST_DRAIN);
            busy_r         <= (next_state_s != ST_IDLE);
            report_valid_r <= (next_state_s == ST_REPORT);
        end
    end

    assign running      = running_r;
    assign busy         = busy_r;
    assign cycle_count  = cycle_count_r;
    assign instr_count  = instr_count_r;
    assign stall_count  = stall_count_r;
    assign ipc_q        = ipc_r;
    assign overflow     = overflow_r;
    assign report_valid = report_valid_r;
endmodule
